// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (TXDATA/STATUS/RXDATA); the RX path is built only with `UART_RX_EN.
// Reads are combinational; TX starts on the accepting store edge; TXDATA stores while busy are dropped.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_write_en,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  output logic [31:0] out_read_data,
  output logic        tx,
  input  logic        rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0] reg_sel;
  logic       wr_txdata, wr_status, tx_busy;
  logic       unused_bits;
  assign reg_sel     = in_address[3:2];
  assign wr_txdata   = in_write_en && (reg_sel == 2'd0);
  assign wr_status   = in_write_en && (reg_sel == 2'd1);
  assign unused_bits = ^{in_address[31:4], in_address[1:0], in_data[31:8]};

  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      txdata_q, txdata_d;
  logic            tx_q, tx_d;

  // Busy check uses the registered state, so a store in the stop bit's last cycle is dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txdata_d   = txdata_q;
    tx_d       = tx_q;
    if (tx_state_q == S_IDLE) begin
      if (wr_txdata) begin
        txdata_d   = in_data[7:0];
        tx_shift_d = in_data[7:0];
        tx_cnt_d   = '0;
        tx_state_d = S_START;
        tx_d       = 1'b0;
      end
    end else if (tx_cnt_q != BIT_LAST) begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
        S_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
        default: begin
          tx_state_d = S_IDLE;
          tx_d       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txdata_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txdata_q   <= txdata_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != S_IDLE);

  logic       rx_valid, overrun;
  logic [7:0] rx_byte;

`ifdef UART_RX_EN
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic          rx_meta_q, rx_sync_q, rx_done;

  // Start is re-checked at half a bit; later samples land mid-bit every CLKS_PER_BIT cycles.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q != HALF_LAST) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q != BIT_LAST) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_cnt_q != BIT_LAST) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          rx_done    = rx_sync_q;
        end
      end
    endcase
    if (wr_status && in_data[0]) rx_valid_d = 1'b0;
    if (wr_status && in_data[1]) overrun_d  = 1'b0;
    if (rx_done) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign rx_byte  = rx_byte_q;
`else
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_valid  = 1'b0;
  assign overrun   = 1'b0;
  assign rx_byte   = 8'h00;
`endif

  always_comb begin
    out_read_data = 32'h0;
    case (reg_sel)
      2'd0:    out_read_data = {24'h0, txdata_q};
      2'd1:    out_read_data = {29'h0, overrun, rx_valid, tx_busy};
      2'd2:    out_read_data = {24'h0, rx_byte};
      default: out_read_data = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at 4 clocks per bit: register-map table, TX frame-window model, RX sequences.
module tb_uart_mmio;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_write_en;
  logic [31:0] in_address;
  logic [31:0] in_data;
  logic [31:0] out_read_data;
  logic        tx;
  logic        rx;

  int checks = 0;
  int failures = 0;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .in_write_en(in_write_en), .in_address(in_address),
    .in_data(in_data), .out_read_data(out_read_data), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // TX reference: a frame occupies 10*CPB cycles from its accepting edge; a store is accepted
  // only when the registered state (as of the previous edge) shows no frame in flight.
  int         cyc = 0;
  int         m_s = 0;
  bit         m_have = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_txd = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_have = 1'b0;
      m_txd  = 8'h00;
    end else if (in_write_en && in_address[3:2] == 2'd0) begin
      if (!(m_have && (cyc - m_s) <= 10 * CPB)) begin
        m_have = 1'b1;
        m_s    = cyc;
        m_byte = in_data[7:0];
        m_txd  = in_data[7:0];
      end
    end
  end

  int   mon_d, mon_k;
  logic mon_tx, mon_busy;
  always @(negedge clk) begin
    mon_tx   = 1'b1;
    mon_busy = 1'b0;
    if (!reset && m_have) begin
      mon_d = cyc - m_s;
      if (mon_d < 10 * CPB) begin
        mon_busy = 1'b1;
        mon_k    = mon_d / CPB;
        if (mon_k == 0)      mon_tx = 1'b0;
        else if (mon_k <= 8) mon_tx = m_byte[mon_k-1];
      end
    end
    chk("tx_line", tx, mon_tx);
    if (in_address[3:2] == 2'd1)      chk("tx_busy", out_read_data[0], mon_busy);
    else if (in_address[3:2] == 2'd0) chk("txdata", out_read_data, reset ? 32'h0 : {24'h0, m_txd});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    in_write_en = we;
    in_address  = a;
    in_data     = d;
    @(posedge clk);
    #1;
    in_write_en = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    in_address = a;
    #1;
    chk(name, out_read_data, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[16];

  int         busy_cycles, low_cnt, lat, r;
  logic [31:0] ra;
  logic [7:0] rb;
  logic       rstop, mv, mo;
  logic [7:0] mb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b0, 32'h0,  32'h0,        32'h0};
    vt[1]  = '{1'b0, 32'h4,  32'h0,        32'h0};
    vt[2]  = '{1'b0, 32'h8,  32'h0,        32'h0};
    vt[3]  = '{1'b0, 32'hC,  32'h0,        32'h0};
    vt[4]  = '{1'b1, 32'hC,  32'hFFFFFFFF, 32'h0};
    vt[5]  = '{1'b1, 32'h8,  32'h5A,       32'h0};
    vt[6]  = '{1'b1, 32'h4,  32'h3,        32'h0};
    vt[7]  = '{1'b0, 32'hC,  32'h0,        32'h0};
    vt[8]  = '{1'b0, 32'h8,  32'h0,        32'h0};
    vt[9]  = '{1'b0, 32'h4,  32'h0,        32'h0};
    vt[10] = '{1'b1, 32'h0,  32'h123456A5, 32'h0};
    vt[11] = '{1'b0, 32'h0,  32'h0,        32'hA5};
    vt[12] = '{1'b0, 32'h4,  32'h0,        32'h1};
    vt[13] = '{1'b1, 32'h0,  32'h3C,       32'hA5};
    vt[14] = '{1'b0, 32'h0,  32'h0,        32'hA5};
    vt[15] = '{1'b0, 32'h10, 32'h0,        32'hA5};

    reset = 1'b1; in_write_en = 1'b0; in_address = 32'h0; in_data = 32'h0; rx = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk_rd("rst_txdata", 32'h0, 32'h0);
    chk_rd("rst_status", 32'h4, 32'h0);
    chk_rd("rst_rxdata", 32'h8, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_write_en = vt[i].we;
      in_address  = vt[i].addr;
      in_data     = vt[i].data;
      #1;
      chk($sformatf("vec%0d", i), out_read_data, vt[i].exp);
      idle(1);
    end
    in_write_en = 1'b0;
    idle(50);

    bus(1'b1, 32'h0, 32'hA5);
    in_address  = 32'h4;
    busy_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_read_data[0]) busy_cycles++;
    end
    chk("busy_width", busy_cycles, 10 * CPB);
    idle(1);

    // Store in the stop bit's final cycle is dropped; the next cycle's store is accepted.
    bus(1'b1, 32'h0, 32'h81);
    idle(10 * CPB - 1);
    bus(1'b1, 32'h0, 32'h3C);
    chk_rd("drop_at_idle", 32'h0, 32'h81);
    bus(1'b1, 32'h0, 32'h5E);
    chk_rd("accept_next", 32'h0, 32'h5E);
    chk_rd("accept_busy", 32'h4, 32'h1);
    idle(45);

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        ra = $urandom;
        bus(1'b1, {ra[31:4], 4'h0}, $urandom);
      end else if (r == 1) begin
        bus(1'b1, 32'hC, $urandom);
      end else begin
        in_address = r[0] ? 32'h4 : 32'h0;
        idle(1);
      end
    end
    idle(50);

    bus(1'b1, 32'h0, 32'hA5);
    idle(14);
    #1 reset = 1'b1;
    #1 chk("midrst_tx", tx, 1'b1);
    chk_rd("midrst_status", 32'h4, 32'h0);
    chk_rd("midrst_txdata", 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    in_address = 32'h4;
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    chk("no_frame_after_reset", low_cnt, 0);
    idle(1);

`ifdef UART_RX_EN
    in_address = 32'h4;
    fork
      send_rx(8'h5A, 1'b1);
      begin
        lat = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          lat++;
          if (out_read_data[1]) break;
        end
      end
    join
    idle(4);
    checks++;
    if (lat < 10 * CPB || lat > 10 * CPB + 2) begin
      failures++;
      $display("FAIL rx_latency: got %0d expected %0d..%0d", lat, 10 * CPB, 10 * CPB + 2);
    end
    chk_rd("rx5a_data", 32'h8, 32'h5A);
    chk_rd("rx5a_status", 32'h4, 32'h2);
    bus(1'b1, 32'h4, 32'h1);
    chk_rd("rx_clear", 32'h4, 32'h0);

    send_rx(8'h11, 1'b1);
    idle(2);
    send_rx(8'h22, 1'b1);
    idle(4);
    chk_rd("ovr_data", 32'h8, 32'h22);
    chk_rd("ovr_status", 32'h4, 32'h6);
    bus(1'b1, 32'h4, 32'h2);
    chk_rd("ovr_clear", 32'h4, 32'h2);
    bus(1'b1, 32'h4, 32'h1);

    send_rx(8'h33, 1'b0);
    idle(3 * CPB);
    chk_rd("frame_err_status", 32'h4, 32'h0);
    chk_rd("frame_err_data", 32'h8, 32'h22);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(3 * CPB);
    chk_rd("glitch_status", 32'h4, 32'h0);
    chk_rd("glitch_data", 32'h8, 32'h22);

    // Clear store lands on the completion edge: completion wins.
    send_rx(8'h96, 1'b1);
    bus(1'b1, 32'h4, 32'h1);
    chk_rd("clr_race_status", 32'h4, 32'h2);
    chk_rd("clr_race_data", 32'h8, 32'h96);

    mv = 1'b1; mo = 1'b0; mb = 8'h96;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus(1'b1, 32'h4, 32'h3);
        mv = 1'b0;
        mo = 1'b0;
      end
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      send_rx(rb, rstop);
      idle(3 * CPB);
      if (rstop) begin
        mo = mo | mv;
        mv = 1'b1;
        mb = rb;
      end
      chk_rd($sformatf("rnd_status%0d", k), 32'h4, {29'h0, mo, mv, 1'b0});
      chk_rd($sformatf("rnd_data%0d", k), 32'h8, {24'h0, mb});
    end
`else
    send_rx(8'h5A, 1'b1);
    idle(4);
    chk_rd("norx_status", 32'h4, 32'h0);
    chk_rd("norx_data", 32'h8, 32'h0);
    bus(1'b1, 32'h4, 32'h3);
    chk_rd("norx_status_wr", 32'h4, 32'h0);
`endif

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
